// File: rtl/cpu_intctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_intctrl - prioritised interrupt controller with CSR port (rev 1.0)     |
// +----------------------------------------------------------------------------+
module cpu_intctrl #(
  parameter int         NUM_SRC    = 8,
  parameter logic [7:0] CAUSE_BASE = 8'h80
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               stall_i,
  input  logic [NUM_SRC-1:0] irq_in_i,
  input  logic               reg_en_i,
  input  logic               reg_we_i,
  input  logic [1:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o,
  input  logic               cpu_int_flag_i,
  output logic               int_req_o,
  output logic [7:0]         int_cause_o,
  input  logic               int_ack_i,
  output logic               in_service_o
);

  localparam logic [1:0] A_ENABLE  = 2'd0;
  localparam logic [1:0] A_PENDING = 2'd1;
  localparam logic [1:0] A_EDGE    = 2'd2;
  localparam logic [1:0] A_CLAIM   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t             state_q;
  logic [NUM_SRC-1:0] enable_q, edge_q, pending_q, pending_d, irq_prev_q;
  logic [3:0]         cur_id_q;
  logic               int_req_q, in_service_q;
  logic [7:0]         int_cause_q;
  logic [31:0]        reg_rdata_q, rdata_d;

  logic               wr_ok, claim_wr, any_eligible, cur_eligible;
  logic [NUM_SRC-1:0] wdata_src, eligible, rise, w1c_mask, ack_clr, cur_onehot;
  logic [3:0]         sel_id;
  logic               unused_wdata;

  assign wr_ok        = reg_en_i & reg_we_i & ~stall_i;
  assign claim_wr     = wr_ok && (reg_addr_i == A_CLAIM);
  assign wdata_src    = reg_wdata_i[NUM_SRC-1:0];
  assign unused_wdata = ^reg_wdata_i;
  assign eligible     = pending_q & enable_q;
  assign any_eligible = |eligible;
  assign rise         = irq_in_i & ~irq_prev_q;
  assign cur_eligible = |(eligible & cur_onehot);
  assign ack_clr      = (state_q == S_REQ && int_ack_i) ? cur_onehot : '0;

  // Descending scan so the lowest eligible index is the one left in sel_id.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel_id = 4'(i);
    end
  end

  always_comb begin
    cur_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cur_onehot[i] = (cur_id_q == 4'(i));
    end
  end

  // New edges are OR-ed in after the clears so a coincident set survives.
  always_comb begin
    w1c_mask  = (wr_ok && reg_addr_i == A_PENDING) ? wdata_src : '0;
    pending_d = (edge_q & ((pending_q & ~w1c_mask & ~ack_clr) | rise))
              | (~edge_q & irq_in_i);
    if (wr_ok && reg_addr_i == A_EDGE) begin
      pending_d = pending_d & ~(edge_q ^ wdata_src);
    end
  end

  always_comb begin
    case (reg_addr_i)
      A_ENABLE:  rdata_d = 32'(enable_q);
      A_PENDING: rdata_d = 32'(pending_q);
      A_EDGE:    rdata_d = 32'(edge_q);
      default:   rdata_d = {in_service_q, int_req_q, 26'b0, cur_id_q};
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      enable_q    <= '0;
      edge_q      <= '0;
      pending_q   <= '0;
      irq_prev_q  <= '0;
      reg_rdata_q <= '0;
    end else begin
      irq_prev_q <= irq_in_i;
      pending_q  <= pending_d;
      if (wr_ok && reg_addr_i == A_ENABLE) enable_q <= wdata_src;
      if (wr_ok && reg_addr_i == A_EDGE)   edge_q   <= wdata_src;
      if (reg_en_i && !stall_i)            reg_rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cur_id_q     <= '0;
      int_cause_q  <= '0;
      int_req_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_eligible && !cpu_int_flag_i) begin
            state_q     <= S_REQ;
            cur_id_q    <= sel_id;
            int_cause_q <= CAUSE_BASE + {4'b0, sel_id};
            int_req_q   <= 1'b1;
          end
        end
        S_REQ: begin
          // Acknowledge takes precedence over a simultaneous source drop.
          if (int_ack_i) begin
            state_q      <= S_SERVICE;
            int_req_q    <= 1'b0;
            in_service_q <= 1'b1;
          end else if (!cur_eligible) begin
            state_q   <= S_IDLE;
            int_req_q <= 1'b0;
          end
        end
        S_SERVICE: begin
          if (claim_wr) begin
            state_q      <= S_IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign reg_rdata_o  = reg_rdata_q;
  assign int_req_o    = int_req_q;
  assign int_cause_o  = int_cause_q;
  assign in_service_o = in_service_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_intctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cpu_intctrl - scoreboard bench for cpu_intctrl (rev 1.0)                |
// +----------------------------------------------------------------------------+
module tb_cpu_intctrl;

  localparam logic [1:0] ENA = 2'd0;
  localparam logic [1:0] PND = 2'd1;
  localparam logic [1:0] EDG = 2'd2;
  localparam logic [1:0] CLM = 2'd3;

  logic        clock, reset, stall, reg_en, reg_we, cpu_int_flag, int_ack;
  logic [7:0]  irq_in;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        int_req, in_service;
  logic [7:0]  int_cause;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  cpu_intctrl #(.NUM_SRC(8), .CAUSE_BASE(8'h80)) dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .stall_i        (stall),
    .irq_in_i       (irq_in),
    .reg_en_i       (reg_en),
    .reg_we_i       (reg_we),
    .reg_addr_i     (reg_addr),
    .reg_wdata_i    (reg_wdata),
    .reg_rdata_o    (reg_rdata),
    .cpu_int_flag_i (cpu_int_flag),
    .int_req_o      (int_req),
    .int_cause_o    (int_cause),
    .int_ack_i      (int_ack),
    .in_service_o   (in_service)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    reg_en = 1'b1; reg_we = 1'b1; reg_addr = addr; reg_wdata = data;
    tick();
    reg_en = 1'b0; reg_we = 1'b0; reg_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    reg_en = 1'b1; reg_we = 1'b0; reg_addr = addr;
    tick();
    reg_en = 1'b0;
  endtask

  // Read data is due one edge after an unstalled read is presented.
  always begin
    @(posedge clock);
    if (reg_en && !reg_we && !stall && !reset) begin
      #1;
      if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      else chk("rdata", reg_rdata, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; reg_en = 1'b0; reg_we = 1'b0; reg_addr = '0;
    reg_wdata = '0; cpu_int_flag = 1'b0; int_ack = 1'b0; irq_in = '0;
    tick(); tick();
    chk("rst_int_req", 32'(int_req), 32'd0);
    chk("rst_cause", 32'(int_cause), 32'h0);
    chk("rst_in_service", 32'(in_service), 32'd0);
    chk("rst_rdata", reg_rdata, 32'h0);
    reset = 1'b0;
    tick();

    // Level source 2: request, ack, complete, re-request while still high
    wr(ENA, 32'h04);
    irq_in = 8'h04;
    tick();
    chk("t1_req_early", 32'(int_req), 32'd0);
    tick();
    chk("t1_req", 32'(int_req), 32'd1);
    chk("t1_cause", 32'(int_cause), 32'h82);
    rd(CLM, 32'h4000_0002);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("t1_ack_req", 32'(int_req), 32'd0);
    chk("t1_ack_insvc", 32'(in_service), 32'd1);
    rd(CLM, 32'h8000_0002);
    wr(CLM, 32'h0);
    chk("t1_done_insvc", 32'(in_service), 32'd0);
    chk("t1_done_req", 32'(int_req), 32'd0);
    tick();
    chk("t1_rereq", 32'(int_req), 32'd1);
    chk("t1_rereq_cause", 32'(int_cause), 32'h82);
    irq_in = 8'h00;
    tick(); tick();
    chk("t1_release", 32'(int_req), 32'd0);

    // Level source 3 released without ack, then release coincident with ack
    wr(ENA, 32'h08);
    irq_in = 8'h08;
    tick(); tick();
    chk("t3_req", 32'(int_req), 32'd1);
    chk("t3_cause", 32'(int_cause), 32'h83);
    irq_in = 8'h00;
    tick();
    chk("t3_req_hold", 32'(int_req), 32'd1);
    tick();
    chk("t3_cancel_req", 32'(int_req), 32'd0);
    chk("t3_cancel_insvc", 32'(in_service), 32'd0);
    irq_in = 8'h08;
    tick(); tick();
    chk("t3_req2", 32'(int_req), 32'd1);
    irq_in = 8'h00;
    tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("t3_ackwin_insvc", 32'(in_service), 32'd1);
    chk("t3_ackwin_req", 32'(int_req), 32'd0);
    wr(CLM, 32'h0);
    tick();
    chk("t3_idle", 32'(int_req), 32'd0);

    // Handler running blocks a new request until the flag clears
    cpu_int_flag = 1'b1;
    irq_in = 8'h08;
    tick(); tick(); tick();
    chk("t4_blocked", 32'(int_req), 32'd0);
    cpu_int_flag = 1'b0;
    tick();
    chk("t4_unblocked", 32'(int_req), 32'd1);
    irq_in = 8'h00;
    tick(); tick();
    chk("t4_release", 32'(int_req), 32'd0);

    // Edge mode: simultaneous pulses on 5 and 1, priority order
    wr(ENA, 32'hFF);
    wr(EDG, 32'hFF);
    irq_in = 8'h22;
    tick();
    irq_in = 8'h00;
    tick();
    chk("t2_req", 32'(int_req), 32'd1);
    chk("t2_cause1", 32'(int_cause), 32'h81);
    rd(PND, 32'h22);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    rd(PND, 32'h20);
    wr(CLM, 32'h0);
    tick();
    chk("t2_cause5", 32'(int_cause), 32'h85);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    rd(PND, 32'h00);
    wr(CLM, 32'h0);

    // Edge set coincident with W1C of the same bit: set wins
    wr(ENA, 32'h00);
    irq_in = 8'h10;
    wr(PND, 32'h10);
    irq_in = 8'h00;
    rd(PND, 32'h10);
    wr(PND, 32'h10);
    rd(PND, 32'h00);

    // Stall blocks both the write and the read capture
    rd(EDG, 32'hFF);
    stall = 1'b1;
    reg_en = 1'b1; reg_we = 1'b1; reg_addr = ENA; reg_wdata = 32'hFF;
    tick();
    reg_we = 1'b0; reg_addr = CLM;
    tick();
    chk("t5_rdata_hold", reg_rdata, 32'hFF);
    reg_en = 1'b0; stall = 1'b0;
    rd(ENA, 32'h00);
    wr(ENA, 32'hFF);
    rd(ENA, 32'hFF);
    rd(CLM, 32'h0000_0005);

    // Reset while in service
    irq_in = 8'h40;
    tick();
    irq_in = 8'h00;
    tick();
    chk("t6_cause6", 32'(int_cause), 32'h86);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("t6_insvc", 32'(in_service), 32'd1);
    reset = 1'b1;
    tick();
    chk("t6_rst_req", 32'(int_req), 32'd0);
    chk("t6_rst_insvc", 32'(in_service), 32'd0);
    chk("t6_rst_cause", 32'(int_cause), 32'h0);
    chk("t6_rst_rdata", reg_rdata, 32'h0);
    reset = 1'b0;
    rd(ENA, 32'h00);
    rd(EDG, 32'h00);
    rd(CLM, 32'h0);
    tick();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
